// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter and HRQ/HLDA/DACK sequencer for NCH channels.
// Conditions raw DREQ pins, merges software requests, and grants one channel at a time.
module dma_priority_arbiter #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned IDXW = $clog2(NCH)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NCH-1:0]  DREQ,
    output logic [NCH-1:0]  DACK,
    output logic            HRQ,
    input  logic            HLDA,
    input  logic [NCH-1:0]  mask,
    input  logic [NCH-1:0]  sw_req_set,
    input  logic [NCH-1:0]  sw_req_clr,
    input  logic            dreq_active_low,
    input  logic            dack_active_low,
    input  logic            rotate_en,
    input  logic            done,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_ch,
    output logic [NCH-1:0]  sw_req
);

    localparam int unsigned SUMW = IDXW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t          state;
    logic [NCH-1:0]  dreq_q;
    logic [NCH-1:0]  req_eff;
    logic [NCH-1:0]  grant_onehot;
    logic [NCH-1:0]  done_clr;
    logic [NCH-1:0]  sw_req_next;
    logic [IDXW-1:0] top;
    logic [IDXW-1:0] next_top;
    logic [IDXW-1:0] search_start;
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] winner;
    logic [SUMW-1:0] search_sum;
    logic            found;

    assign req_eff      = (dreq_q | sw_req) & ~mask;
    assign grant_onehot = NCH'(1) << grant_ch;
    assign done_clr     = (state == GRANT && done) ? grant_onehot : '0;
    // A set pulse beats both an explicit clear and the completion clear.
    assign sw_req_next  = (sw_req & ~sw_req_clr & ~done_clr) | sw_req_set;
    assign next_top     = (grant_ch == IDXW'(NCH - 1)) ? '0 : grant_ch + IDXW'(1);
    assign search_start = rotate_en ? top : '0;

    // First requesting channel at or after search_start, wrapping modulo NCH.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        search_sum = '0;
        cand       = '0;
        for (int i = 0; i < NCH; i++) begin
            search_sum = {1'b0, search_start} + SUMW'(i);
            if (search_sum >= SUMW'(NCH)) begin
                search_sum = search_sum - SUMW'(NCH);
            end
            cand = search_sum[IDXW-1:0];
            if (!found && req_eff[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Sequencer: all outputs are registered and derived from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            HRQ         <= 1'b0;
            grant_valid <= 1'b0;
            grant_ch    <= '0;
            sw_req      <= '0;
            top         <= '0;
            dreq_q      <= '0;
            DACK        <= {NCH{dack_active_low}};
        end else begin
            dreq_q <= DREQ ^ {NCH{dreq_active_low}};
            sw_req <= sw_req_next;
            DACK   <= {NCH{dack_active_low}};
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_ch <= winner;
                        state    <= REQ;
                        HRQ      <= 1'b1;
                    end
                end
                REQ: begin
                    if (HLDA) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        DACK        <= grant_onehot ^ {NCH{dack_active_low}};
                    end else if (!req_eff[grant_ch]) begin
                        state <= IDLE;
                        HRQ   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (done) begin
                        state       <= IDLE;
                        HRQ         <= 1'b0;
                        grant_valid <= 1'b0;
                        if (rotate_en) begin
                            top <= next_top;
                        end
                    end else if (!HLDA) begin
                        state       <= IDLE;
                        HRQ         <= 1'b0;
                        grant_valid <= 1'b0;
                    end else begin
                        DACK <= grant_onehot ^ {NCH{dack_active_low}};
                    end
                end
                default: begin
                    state       <= IDLE;
                    HRQ         <= 1'b0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter (NCH=4 and NCH=8 instances).
module tb_dma_priority_arbiter;

    logic       clk;
    logic       rst;
    int         checks;
    int         errors;

    logic [3:0] d4_dreq, d4_dack, d4_mask, d4_set, d4_clr, d4_swreq;
    logic       d4_hrq, d4_hlda, d4_dreq_al, d4_dack_al, d4_rot, d4_done, d4_gv;
    logic [1:0] d4_gch;

    logic [7:0] d8_dreq, d8_dack, d8_mask, d8_set, d8_clr, d8_swreq;
    logic       d8_hrq, d8_hlda, d8_dreq_al, d8_dack_al, d8_rot, d8_done, d8_gv;
    logic [2:0] d8_gch;

    dma_priority_arbiter #(.NCH(4)) u_dut4 (
        .CLK(clk), .RESET(rst), .DREQ(d4_dreq), .DACK(d4_dack), .HRQ(d4_hrq),
        .HLDA(d4_hlda), .mask(d4_mask), .sw_req_set(d4_set), .sw_req_clr(d4_clr),
        .dreq_active_low(d4_dreq_al), .dack_active_low(d4_dack_al),
        .rotate_en(d4_rot), .done(d4_done), .grant_valid(d4_gv),
        .grant_ch(d4_gch), .sw_req(d4_swreq)
    );

    dma_priority_arbiter #(.NCH(8)) u_dut8 (
        .CLK(clk), .RESET(rst), .DREQ(d8_dreq), .DACK(d8_dack), .HRQ(d8_hrq),
        .HLDA(d8_hlda), .mask(d8_mask), .sw_req_set(d8_set), .sw_req_clr(d8_clr),
        .dreq_active_low(d8_dreq_al), .dack_active_low(d8_dack_al),
        .rotate_en(d8_rot), .done(d8_done), .grant_valid(d8_gv),
        .grant_ch(d8_gch), .sw_req(d8_swreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_all();
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b exp 0", d4_hrq); end
        checks++; if (d4_gv !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b exp 0", d4_gv); end
        checks++; if (d4_gch !== 2'd0) begin errors++; $display("FAIL reset_gch: got %0d exp 0", d4_gch); end
        checks++; if (d4_swreq !== 4'b0000) begin errors++; $display("FAIL reset_swreq: got %b exp 0000", d4_swreq); end
        checks++; if (d4_dack !== 4'b0000) begin errors++; $display("FAIL reset_dack: got %b exp 0000", d4_dack); end
        tick(1);
        checks++; if (d4_dack !== 4'b0000) begin errors++; $display("FAIL reset_dack_idle: got %b exp 0000", d4_dack); end
    endtask

    task automatic test_fixed();
        reset_all();
        d4_rot  = 1'b0;
        d4_dreq = 4'b1010;
        tick(1);
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL fixed_hrq_early: got %b exp 0", d4_hrq); end
        tick(1);
        checks++; if (d4_hrq !== 1'b1) begin errors++; $display("FAIL fixed_hrq: got %b exp 1", d4_hrq); end
        checks++; if (d4_gch !== 2'd1) begin errors++; $display("FAIL fixed_gch1: got %0d exp 1", d4_gch); end
        tick(1);
        checks++; if (d4_dack !== 4'b0000) begin errors++; $display("FAIL fixed_dack_req: got %b exp 0000", d4_dack); end
        d4_hlda = 1'b1;
        tick(1);
        checks++; if (d4_dack !== 4'b0010) begin errors++; $display("FAIL fixed_dack_grant: got %b exp 0010", d4_dack); end
        checks++; if (d4_gv !== 1'b1) begin errors++; $display("FAIL fixed_gv: got %b exp 1", d4_gv); end
        tick(1);
        checks++; if (d4_dack !== 4'b0010) begin errors++; $display("FAIL fixed_dack_hold: got %b exp 0010", d4_dack); end
        d4_dreq = 4'b1000;
        d4_done = 1'b1;
        tick(1);
        d4_done = 1'b0;
        checks++; if (d4_dack !== 4'b0000) begin errors++; $display("FAIL fixed_dack_done: got %b exp 0000", d4_dack); end
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL fixed_hrq_done: got %b exp 0", d4_hrq); end
        checks++; if (d4_gv !== 1'b0) begin errors++; $display("FAIL fixed_gv_done: got %b exp 0", d4_gv); end
        tick(1);
        checks++; if (d4_gch !== 2'd3) begin errors++; $display("FAIL fixed_gch3: got %0d exp 3", d4_gch); end
        checks++; if (d4_hrq !== 1'b1) begin errors++; $display("FAIL fixed_hrq_rearb: got %b exp 1", d4_hrq); end
        tick(1);
        checks++; if (d4_dack !== 4'b1000) begin errors++; $display("FAIL fixed_dack3: got %b exp 1000", d4_dack); end
        d4_done = 1'b1;
        d4_dreq = 4'b0000;
        d4_hlda = 1'b0;
        tick(1);
        d4_done = 1'b0;
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL fixed_hrq_end: got %b exp 0", d4_hrq); end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_order [5];
        logic [3:0] exp_dack;
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset_all();
        d4_rot  = 1'b1;
        d4_hlda = 1'b1;
        d4_dreq = 4'b1111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            tick(2);
            exp_dack = 4'b0001 << exp_order[k];
            checks++; if (d4_gch !== exp_order[k]) begin errors++; $display("FAIL rotate_gch[%0d]: got %0d exp %0d", k, d4_gch, exp_order[k]); end
            checks++; if (d4_dack !== exp_dack) begin errors++; $display("FAIL rotate_dack[%0d]: got %b exp %b", k, d4_dack, exp_dack); end
            d4_done = 1'b1;
            tick(1);
            d4_done = 1'b0;
            checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL rotate_idle[%0d]: got hrq %b exp 0", k, d4_hrq); end
        end
        d4_dreq = 4'b0000;
        d4_hlda = 1'b0;
        d4_rot  = 1'b0;
        tick(1);
    endtask

    task automatic test_polarity();
        d4_dreq_al = 1'b1;
        d4_dack_al = 1'b1;
        d4_dreq    = 4'b1111;
        reset_all();
        checks++; if (d4_dack !== 4'b1111) begin errors++; $display("FAIL pol_reset_dack: got %b exp 1111", d4_dack); end
        d4_dreq = 4'b1011;
        d4_hlda = 1'b1;
        tick(1);
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL pol_hrq_early: got %b exp 0", d4_hrq); end
        tick(1);
        checks++; if (d4_gch !== 2'd2) begin errors++; $display("FAIL pol_gch: got %0d exp 2", d4_gch); end
        checks++; if (d4_dack !== 4'b1111) begin errors++; $display("FAIL pol_dack_req: got %b exp 1111", d4_dack); end
        tick(1);
        checks++; if (d4_dack !== 4'b1011) begin errors++; $display("FAIL pol_dack_grant: got %b exp 1011", d4_dack); end
        d4_dack_al = 1'b0;
        tick(1);
        checks++; if (d4_dack !== 4'b0100) begin errors++; $display("FAIL pol_dack_flip: got %b exp 0100", d4_dack); end
        d4_done    = 1'b1;
        d4_dreq    = 4'b0000;
        d4_dreq_al = 1'b0;
        d4_hlda    = 1'b0;
        tick(1);
        d4_done = 1'b0;
        checks++; if (d4_dack !== 4'b0000) begin errors++; $display("FAIL pol_dack_done: got %b exp 0000", d4_dack); end
    endtask

    task automatic test_sw_req_mask();
        reset_all();
        d4_mask = 4'b0100;
        d4_set  = 4'b0100;
        tick(1);
        d4_set = 4'b0000;
        checks++; if (d4_swreq !== 4'b0100) begin errors++; $display("FAIL sw_set: got %b exp 0100", d4_swreq); end
        d4_done = 1'b1;
        tick(1);
        d4_done = 1'b0;
        tick(2);
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL sw_masked_hrq: got %b exp 0", d4_hrq); end
        checks++; if (d4_swreq !== 4'b0100) begin errors++; $display("FAIL sw_idle_done: got %b exp 0100", d4_swreq); end
        d4_mask = 4'b0000;
        tick(1);
        checks++; if (d4_hrq !== 1'b1) begin errors++; $display("FAIL sw_unmask_hrq: got %b exp 1", d4_hrq); end
        checks++; if (d4_gch !== 2'd2) begin errors++; $display("FAIL sw_gch: got %0d exp 2", d4_gch); end
        d4_done = 1'b1;
        tick(1);
        d4_done = 1'b0;
        checks++; if (d4_hrq !== 1'b1) begin errors++; $display("FAIL sw_req_done_ignored: got %b exp 1", d4_hrq); end
        d4_hlda = 1'b1;
        tick(1);
        checks++; if (d4_dack !== 4'b0100) begin errors++; $display("FAIL sw_dack: got %b exp 0100", d4_dack); end
        d4_done = 1'b1;
        tick(1);
        d4_done = 1'b0;
        d4_hlda = 1'b0;
        checks++; if (d4_swreq !== 4'b0000) begin errors++; $display("FAIL sw_done_clear: got %b exp 0000", d4_swreq); end
        tick(2);
        checks++; if (d4_hrq !== 1'b0) begin errors++; $display("FAIL sw_no_rereq: got %b exp 0", d4_hrq); end
        d4_mask = 4'b1111;
        d4_set  = 4'b0001;
        d4_clr  = 4'b0001;
        tick(1);
        d4_set = 4'b0000;
        checks++; if (d4_swreq !== 4'b0001) begin errors++; $display("FAIL sw_set_wins: got %b exp 0001", d4_swreq); end
        tick(1);
        d4_clr = 4'b0000;
        checks++; if (d4_swreq !== 4'b0000) begin errors++; $display("FAIL sw_clr: got %b exp 0000", d4_swreq); end
        d4_mask = 4'b0000;
    endtask

    task automatic test_abort();
        reset_all();
        d4_rot  = 1'b1;
        d4_hlda = 1'b1;
        d4_dreq = 4'b0010;
        tick(3);
        checks++; if (d4_dack !== 4'b0010) begin errors++; $display("FAIL abort_dack_grant: got %b exp 0010", d4_dack); end
        d4_hlda = 1'b0;
        d4_dreq = 4'b1010;
        tick(1);
        checks++; if (d4_dack !== 4'b0000) begin errors++; $display("FAIL abort_dack: got %b exp 0000", d4_dack); end
        checks++; if (d4_gv !== 1'b0) begin errors++; $display("FAIL abort_gv: got %b exp 0", d4_gv); end
        tick(1);
        checks++; if (d4_gch !== 2'd1) begin errors++; $display("FAIL abort_top_kept: got %0d exp 1", d4_gch); end
        d4_done = 1'b1;
        tick(1);
        d4_done = 1'b0;
        checks++; if (d4_hrq !== 1'b1) begin errors++; $display("FAIL abort_req_hold: got %b exp 1", d4_hrq); end
        d4_hlda = 1'b1;
        tick(1);
        checks++; if (d4_dack !== 4'b0010) begin errors++; $display("FAIL abort_regrant: got %b exp 0010", d4_dack); end
        d4_mask = 4'b1111;
        tick(1);
        checks++; if (d4_dack !== 4'b0010 || d4_gv !== 1'b1) begin errors++; $display("FAIL abort_no_preempt: got dack %b gv %b exp 0010 1", d4_dack, d4_gv); end
        d4_mask = 4'b0000;
        d4_done = 1'b1;
        tick(1);
        d4_done = 1'b0;
        tick(1);
        checks++; if (d4_gch !== 2'd3) begin errors++; $display("FAIL abort_rotate_after_done: got %0d exp 3", d4_gch); end
        tick(1);
        d4_done = 1'b1;
        d4_dreq = 4'b0000;
        d4_hlda = 1'b0;
        d4_rot  = 1'b0;
        tick(1);
        d4_done = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        reset_all();
        d4_dreq = 4'b0001;
        d4_hlda = 1'b1;
        tick(3);
        checks++; if (d4_dack !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b exp 0001", d4_dack); end
        rst = 1'b1;
        tick(1);
        checks++; if (d4_dack !== 4'b0000 || d4_hrq !== 1'b0 || d4_gv !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got dack %b hrq %b gv %b exp 0000 0 0", d4_dack, d4_hrq, d4_gv); end
        rst     = 1'b0;
        d4_dreq = 4'b0000;
        d4_hlda = 1'b0;
        tick(1);
    endtask

    task automatic test_nch8_wrap();
        reset_all();
        d8_rot  = 1'b1;
        d8_hlda = 1'b1;
        d8_dreq = 8'b0010_0000;
        tick(2);
        checks++; if (d8_gch !== 3'd5) begin errors++; $display("FAIL n8_first: got %0d exp 5", d8_gch); end
        tick(1);
        checks++; if (d8_dack !== 8'b0010_0000) begin errors++; $display("FAIL n8_dack5: got %b exp 00100000", d8_dack); end
        d8_done = 1'b1;
        d8_dreq = 8'b0010_0001;
        tick(1);
        d8_done = 1'b0;
        tick(1);
        checks++; if (d8_gch !== 3'd0) begin errors++; $display("FAIL n8_wrap: got %0d exp 0", d8_gch); end
        tick(1);
        checks++; if (d8_dack !== 8'b0000_0001) begin errors++; $display("FAIL n8_dack0: got %b exp 00000001", d8_dack); end
        d8_done = 1'b1;
        tick(1);
        d8_done = 1'b0;
        tick(1);
        checks++; if (d8_gch !== 3'd5) begin errors++; $display("FAIL n8_then5: got %0d exp 5", d8_gch); end
        tick(1);
        checks++; if (d8_dack !== 8'b0010_0000) begin errors++; $display("FAIL n8_dack5b: got %b exp 00100000", d8_dack); end
        d8_done = 1'b1;
        d8_dreq = 8'b0000_0000;
        d8_hlda = 1'b0;
        tick(1);
        d8_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        d4_dreq = '0; d4_mask = '0; d4_set = '0; d4_clr = '0;
        d4_hlda = 1'b0; d4_dreq_al = 1'b0; d4_dack_al = 1'b0; d4_rot = 1'b0; d4_done = 1'b0;
        d8_dreq = '0; d8_mask = '0; d8_set = '0; d8_clr = '0;
        d8_hlda = 1'b0; d8_dreq_al = 1'b0; d8_dack_al = 1'b0; d8_rot = 1'b0; d8_done = 1'b0;
        test_reset();
        test_fixed();
        test_rotate();
        test_polarity();
        test_sw_req_mask();
        test_abort();
        test_reset_mid_grant();
        test_nch8_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
